board_io_bridge: RTL and testbench

BOARD_IO_BRIDGE -- requirements
Module: board_io_bridge

---
 rtl/board_io_pkg.sv | 30 +++
 rtl/board_io_bridge_sw_debounce.sv | 61 ++++++
 rtl/board_io_bridge.sv | 158 +++++++++++++++
 tb/tb_board_io_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// board_io_pkg: shared types and constants for the board I/O bridge.
//   lcd_state_e  - LCD strobe sequencer states
//   HEX_GLYPH    - seven-segment glyphs for 0-F, order {g,f,e,d,c,b,a}, active-high
//   LCD_*_BIT    - field positions inside the core LCD register
//   cnt_width()  - counter width for a modulus, never below one bit
package board_io_pkg;

  typedef enum logic [1:0] {
    LCD_IDLE,
    LCD_SETUP,
    LCD_PULSE,
    LCD_HOLD
  } lcd_state_e;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int unsigned LCD_ON_BIT   = 31;
  localparam int unsigned LCD_EN_BIT   = 10;
  localparam int unsigned LCD_RS_BIT   = 9;
  localparam int unsigned LCD_RW_BIT   = 8;
  localparam int unsigned LCD_DATA_LSB = 0;

  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/board_io_bridge_sw_debounce.sv
// sw_debounce: 2-flop synchroniser followed by a periodic sampler.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   sw_raw_i       - asynchronous switch inputs
//   sw_o           - debounced switches; a bit changes only when two
//                    consecutive tick samples agree
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned N_SW     = 18,
  parameter int unsigned DEB_TICK = 500000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_SW-1:0] sw_raw_i,
  output logic [N_SW-1:0] sw_o
);

  localparam int unsigned   CW        = cnt_width(DEB_TICK);
  localparam logic [CW-1:0] TICK_LAST = CW'(DEB_TICK - 1);

  logic [N_SW-1:0] sync1_q, sync1_d;
  logic [N_SW-1:0] sync2_q, sync2_d;
  logic [N_SW-1:0] last_q, last_d;
  logic [N_SW-1:0] sw_q, sw_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [N_SW-1:0] agree;

  always_comb begin
    sync1_d    = sw_raw_i;
    sync2_d    = sync1_q;
    last_d     = last_q;
    sw_d       = sw_q;
    tick_cnt_d = tick_cnt_q + CW'(1);
    agree      = ~(sync2_q ^ last_q);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      last_d     = sync2_q;
      // Bits whose new sample matches the previous one take it; others hold.
      sw_d       = (sw_q & ~agree) | (sync2_q & agree);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      last_q     <= '0;
      sw_q       <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      last_q     <= last_d;
      sw_q       <= sw_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign sw_o = sw_q;

endmodule

// File: rtl/board_io_bridge.sv
// board_io_bridge: glue between the board pins and the core registers.
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   sw_raw_i / sw_o        - raw switches in, debounced switches out
//   ce_o                   - one-cycle enable every CE_DIV cycles
//   hex_i, hex_mode_i      - per-digit 32-bit registers and glyph/raw select
//   hex_n_o                - active-low segments, 7 bits per digit, registered
//   lcd_i                  - core LCD register (ON, EN request, RS, RW, DATA)
//   lcd_*_o, lcd_busy_o    - LCD pins and strobe-in-progress flag
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int unsigned N_SW       = 18,
  parameter int unsigned N_HEX      = 8,
  parameter int unsigned DEB_TICK   = 500000,
  parameter int unsigned CE_DIV     = 2,
  parameter int unsigned LCD_EN_CYC = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SW-1:0]     sw_raw_i,
  output logic [N_SW-1:0]     sw_o,
  output logic                ce_o,
  input  logic [32*N_HEX-1:0] hex_i,
  input  logic [N_HEX-1:0]    hex_mode_i,
  output logic [7*N_HEX-1:0]  hex_n_o,
  input  logic [31:0]         lcd_i,
  output logic                lcd_on_o,
  output logic                lcd_en_o,
  output logic                lcd_rs_o,
  output logic                lcd_rw_o,
  output logic [7:0]          lcd_data_o,
  output logic                lcd_busy_o
);

  localparam int unsigned    CEW     = cnt_width(CE_DIV);
  localparam logic [CEW-1:0] CE_LAST = CEW'(CE_DIV - 1);
  localparam int unsigned    ENW     = cnt_width(LCD_EN_CYC);
  localparam logic [ENW-1:0] EN_LAST = ENW'(LCD_EN_CYC - 1);

  sw_debounce #(
    .N_SW     (N_SW),
    .DEB_TICK (DEB_TICK)
  ) u_sw_debounce (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sw_raw_i (sw_raw_i),
    .sw_o     (sw_o)
  );

  logic [CEW-1:0]       ce_cnt_q, ce_cnt_d;
  logic                 ce_q, ce_d;
  logic [7*N_HEX-1:0]   hex_q, hex_d;
  lcd_state_e           state_q, state_d;
  logic [ENW-1:0]       pulse_cnt_q, pulse_cnt_d;
  logic                 en_prev_q, en_prev_d;
  logic                 on_q, on_d;
  logic                 rs_q, rs_d;
  logic                 rw_q, rw_d;
  logic [7:0]           data_q, data_d;
  logic                 unused_hex_bits;
  logic                 unused_lcd_bits;

  assign unused_hex_bits = ^hex_i;
  assign unused_lcd_bits = ^lcd_i[30:11];

  // Enable divider: pulse on the count that wraps, so the first pulse lands
  // CE_DIV cycles after reset release and CE_DIV=1 gives a constant high.
  always_comb begin
    ce_cnt_d = ce_cnt_q + CEW'(1);
    ce_d     = 1'b0;
    if (ce_cnt_q == CE_LAST) begin
      ce_cnt_d = '0;
      ce_d     = 1'b1;
    end
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned k = 0; k < N_HEX; k++) begin
      if (hex_mode_i[k]) begin
        hex_d[7*k +: 7] = ~HEX_GLYPH[hex_i[32*k +: 4]];
      end else begin
        hex_d[7*k +: 7] = ~hex_i[32*k +: 7];
      end
    end
  end

  // The edge register tracks EN in every state, so a request left high
  // across a strobe never produces a fresh edge on return to IDLE.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    rs_d        = rs_q;
    rw_d        = rw_q;
    data_d      = data_q;
    en_prev_d   = lcd_i[LCD_EN_BIT];
    on_d        = lcd_i[LCD_ON_BIT];
    case (state_q)
      LCD_IDLE: begin
        if (lcd_i[LCD_EN_BIT] && !en_prev_q) begin
          state_d = LCD_SETUP;
          rs_d    = lcd_i[LCD_RS_BIT];
          rw_d    = lcd_i[LCD_RW_BIT];
          data_d  = lcd_i[LCD_DATA_LSB +: 8];
        end
      end
      LCD_SETUP: begin
        state_d     = LCD_PULSE;
        pulse_cnt_d = '0;
      end
      LCD_PULSE: begin
        if (pulse_cnt_q == EN_LAST) begin
          state_d = LCD_HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + ENW'(1);
        end
      end
      LCD_HOLD: state_d = LCD_IDLE;
      default:  state_d = LCD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ce_cnt_q    <= '0;
      ce_q        <= 1'b0;
      hex_q       <= '1;
      state_q     <= LCD_IDLE;
      pulse_cnt_q <= '0;
      en_prev_q   <= 1'b0;
      on_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      ce_cnt_q    <= ce_cnt_d;
      ce_q        <= ce_d;
      hex_q       <= hex_d;
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      en_prev_q   <= en_prev_d;
      on_q        <= on_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
    end
  end

  assign ce_o       = ce_q;
  assign hex_n_o    = hex_q;
  assign lcd_on_o   = on_q;
  assign lcd_en_o   = (state_q == LCD_PULSE);
  assign lcd_busy_o = (state_q != LCD_IDLE);
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = rw_q;
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// tb_board_io_bridge: directed bench for board_io_bridge.
//   DUT a: DEB_TICK=4, CE_DIV=3, LCD_EN_CYC=4.  DUT b: same with CE_DIV=1.
module tb_board_io_bridge;

  localparam int unsigned N_SW  = 8;
  localparam int unsigned N_HEX = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N_SW-1:0]      sw_raw;
  logic [32*N_HEX-1:0]  hex;
  logic [N_HEX-1:0]     mode;
  logic [31:0]          lcd;

  logic [N_SW-1:0]      sw_a, sw_b;
  logic                 ce_a, ce_b;
  logic [7*N_HEX-1:0]   hex_n_a, hex_n_b;
  logic                 on_a, en_a, rs_a, rw_a, busy_a;
  logic                 on_b, en_b, rs_b, rw_b, busy_b;
  logic [7:0]           data_a, data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_io_bridge #(
    .N_SW(N_SW), .N_HEX(N_HEX), .DEB_TICK(4), .CE_DIV(3), .LCD_EN_CYC(4)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .sw_raw_i(sw_raw), .sw_o(sw_a), .ce_o(ce_a),
    .hex_i(hex), .hex_mode_i(mode), .hex_n_o(hex_n_a), .lcd_i(lcd),
    .lcd_on_o(on_a), .lcd_en_o(en_a), .lcd_rs_o(rs_a), .lcd_rw_o(rw_a),
    .lcd_data_o(data_a), .lcd_busy_o(busy_a)
  );

  board_io_bridge #(
    .N_SW(N_SW), .N_HEX(N_HEX), .DEB_TICK(4), .CE_DIV(1), .LCD_EN_CYC(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .sw_raw_i(sw_raw), .sw_o(sw_b), .ce_o(ce_b),
    .hex_i(hex), .hex_mode_i(mode), .hex_n_o(hex_n_b), .lcd_i(lcd),
    .lcd_on_o(on_b), .lcd_en_o(en_b), .lcd_rs_o(rs_b), .lcd_rw_o(rw_b),
    .lcd_data_o(data_b), .lcd_busy_o(busy_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive sw_raw[3] to v for n cycles, checking the debounced vector each cycle.
  task automatic hold_raw(input logic v, input int unsigned n, input logic exp_sw);
    sw_raw[3] = v;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      chk("sw_hold", 64'(sw_a), exp_sw ? 64'h08 : 64'h00);
    end
  endtask

  typedef struct {
    logic [63:0] hex;
    logic [1:0]  mode;
    logic [13:0] exp;
  } hex_vec_t;

  hex_vec_t hv [8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] prev_hex;
    logic [6:0]  en_pat;
    logic [6:0]  busy_pat;
    logic        seen;

    hv[0] = '{{32'h0, 32'h5},                 2'b11, {7'h40, 7'h12}};
    hv[1] = '{{32'h8, 32'h0},                 2'b11, {7'h00, 7'h40}};
    hv[2] = '{{32'hA, 32'hB},                 2'b11, {7'h08, 7'h03}};
    hv[3] = '{{32'hF, 32'h7F},                2'b10, {7'h0E, 7'h00}};
    hv[4] = '{{32'h55, 32'hFFFF_FF80},        2'b00, {7'h2A, 7'h7F}};
    hv[5] = '{{32'h1234_5679, 32'h3},         2'b01, {7'h06, 7'h30}};
    hv[6] = '{{32'hC, 32'hD},                 2'b11, {7'h46, 7'h21}};
    hv[7] = '{{32'h1, 32'hE},                 2'b11, {7'h79, 7'h06}};
    en_pat   = 7'b0011110;
    busy_pat = 7'b0111111;

    // Reset with every input driven active.
    sw_raw = '1;
    hex    = 64'h0000_0008_0000_0008;
    mode   = '1;
    lcd    = 32'h8000_07FF;
    repeat (3) tick();
    chk("rst_sw",   64'(sw_a),    64'h0);
    chk("rst_ce_a", 64'(ce_a),    64'h0);
    chk("rst_ce_b", 64'(ce_b),    64'h0);
    chk("rst_hex",  64'(hex_n_a), 64'h3FFF);
    chk("rst_lcd",  64'({on_a, en_a, rs_a, rw_a, data_a, busy_a}), 64'h0);

    // Enable divider from reset release.
    sw_raw = '0;
    lcd    = '0;
    rst_ni = 1'b1;
    for (int unsigned k = 1; k <= 12; k++) begin
      tick();
      chk("ce_div3", 64'(ce_a), 64'((k % 3) == 0));
      chk("ce_div1", 64'(ce_b), 64'h1);
    end

    // Seven-segment table.
    hex  = '0;
    mode = '0;
    tick();
    chk("hex_raw_zero", 64'(hex_n_a), 64'h3FFF);
    prev_hex = 14'h3FFF;
    for (int unsigned i = 0; i < 8; i++) begin
      hex  = hv[i].hex;
      mode = hv[i].mode;
      #1;
      chk("hex_latency", 64'(hex_n_a), 64'(prev_hex));
      tick();
      chk("hex_vec", 64'(hex_n_a), 64'(hv[i].exp));
      prev_hex = hv[i].exp;
    end

    // Debounce: short 1-glitches, then a stable rise.
    hold_raw(1'b0, 10, 1'b0);
    hold_raw(1'b1, 2, 1'b0);
    hold_raw(1'b0, 8, 1'b0);
    hold_raw(1'b1, 3, 1'b0);
    hold_raw(1'b0, 8, 1'b0);
    hold_raw(1'b1, 1, 1'b0);
    hold_raw(1'b0, 10, 1'b0);
    sw_raw[3] = 1'b1;
    for (int unsigned n = 1; n <= 6; n++) begin
      tick();
      chk("sw_rise_early", 64'(sw_a), 64'h00);
    end
    seen = 1'b0;
    for (int unsigned n = 7; n <= 10 && !seen; n++) begin
      tick();
      seen = sw_a[3];
    end
    chk("sw_rise_window", 64'(seen), 64'h1);
    chk("sw_rise_value",  64'(sw_a), 64'h08);
    hold_raw(1'b1, 6, 1'b1);
    hold_raw(1'b0, 2, 1'b1);
    hold_raw(1'b1, 8, 1'b1);
    hold_raw(1'b0, 3, 1'b1);
    hold_raw(1'b1, 10, 1'b1);
    sw_raw[3] = 1'b0;
    for (int unsigned n = 1; n <= 6; n++) begin
      tick();
      chk("sw_fall_early", 64'(sw_a), 64'h08);
    end
    seen = 1'b0;
    for (int unsigned n = 7; n <= 10 && !seen; n++) begin
      tick();
      seen = !sw_a[3];
    end
    chk("sw_fall_window", 64'(seen), 64'h1);

    // LCD strobe: ON, EN, RS=1, RW=0, DATA=0x41.
    sw_raw = '1;
    lcd    = '0;
    tick();
    lcd = 32'h8000_0641;
    #1;
    chk("lcd_busy_pre", 64'(busy_a), 64'h0);
    chk("lcd_on_pre",   64'(on_a),   64'h0);
    for (int unsigned i = 1; i <= 7; i++) begin
      tick();
      chk("lcd1_en",   64'(en_a),   64'(en_pat[i-1]));
      chk("lcd1_busy", 64'(busy_a), 64'(busy_pat[i-1]));
      chk("lcd1_on",   64'(on_a),   64'h1);
      if (i <= 6) chk("lcd1_bus", 64'({rs_a, rw_a, data_a}), 64'h241);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("lcd1_no_retrigger", 64'(busy_a), 64'h0);
    end

    // Second EN edge arriving mid-PULSE with different fields is ignored.
    lcd = 32'h8000_0000;
    tick();
    lcd = 32'h8000_055A;
    for (int unsigned i = 1; i <= 7; i++) begin
      tick();
      chk("lcd2_en",   64'(en_a),   64'(en_pat[i-1]));
      chk("lcd2_busy", 64'(busy_a), 64'(busy_pat[i-1]));
      if (i <= 6) chk("lcd2_bus", 64'({rs_a, rw_a, data_a}), 64'h15A);
      if (i == 2) lcd = 32'h8000_02FF;
      if (i == 3) lcd = 32'h8000_06FF;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      chk("lcd2_no_retrigger", 64'(busy_a), 64'h0);
    end
    chk("sw_all_high", 64'(sw_a), 64'hFF);

    // Reset asserted mid-PULSE.
    lcd = 32'h8000_0000;
    tick();
    lcd = 32'h8000_0641;
    repeat (3) tick();
    chk("lcd3_en_pre_rst", 64'(en_a), 64'h1);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_sw",   64'(sw_a),    64'h0);
    chk("mid_rst_ce_a", 64'(ce_a),    64'h0);
    chk("mid_rst_ce_b", 64'(ce_b),    64'h0);
    chk("mid_rst_hex",  64'(hex_n_a), 64'h3FFF);
    chk("mid_rst_lcd",  64'({on_a, en_a, rs_a, rw_a, data_a, busy_a}), 64'h0);
    lcd    = '0;
    rst_ni = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", 64'(busy_a), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
